uart_rx: RTL and testbench

//  UART receiver paired with the UART transmitter: 8N1 frames, LSB first, idle-high line.

---
 rtl/uart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART receiver for 8N1-style frames (LSB first, idle-high line). The async
//   rx pin is brought into the clk domain by a 2-FF synchroniser. A tick
//   generator produces OVERSAMPLE ticks per bit, which are used to find the
//   centre of each bit. Each received byte is held behind a sticky
//   valid/ack handshake. Framing errors (stop bit low) and overruns (a new
//   byte arrives while the old one is still unacknowledged) are flagged.
//
// Ports
//   clk        in   1           system clock
//   rst        in   1           synchronous, active-high reset
//   rx         in   1           async serial input (idle high)
//   rx_ack     in   1           consumer takes the byte; clears rx_valid next clk
//   data_o     out  DATA_WIDTH  last good byte, stable while rx_valid=1
//   rx_valid   out  1           byte available; sticky until rx_ack
//   rx_busy    out  1           1 whenever the receiver is not idle
//   frame_err  out  1           1-clk pulse: stop bit sampled low
//   overrun    out  1           sticky: good byte overwrote an unacknowledged one
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int BAUDRATE     = 9600,
  parameter int CLK_FREQ_MHZ = 125,
  parameter int OVERSAMPLE   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  rx_ack,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rx_valid,
  output logic                  rx_busy,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int TICK_RAW   = CLK_FREQ_MHZ * 1_000_000 / (BAUDRATE * OVERSAMPLE);
  localparam int TICK_COUNT = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int TICK_W     = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int SAMP_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT - 1);
  // The start bit is checked half a bit in; every later sample is a full bit on.
  localparam logic [SAMP_W-1:0] HALF_LAST = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] FULL_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // Synchroniser and edge-detect history
  logic sync1_q;
  logic rx_s_q;
  logic rx_prev_q;

  state_e                  state_q,    state_d;
  logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [SAMP_W-1:0]       samp_cnt_q, samp_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q,  bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q,    shift_d;
  logic [DATA_WIDTH-1:0]   data_q,     data_d;
  logic                    valid_q,    valid_d;
  logic                    ferr_q,     ferr_d;
  logic                    overrun_q,  overrun_d;

  logic tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    overrun_d  = overrun_q;

    // Acknowledge only matters when a byte is actually pending.
    if (rx_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // Edge, not level: a held-low (break) line cannot retrigger.
        if (rx_prev_q && !rx_s_q) begin
          state_d    = START;
          tick_cnt_d = '0;
          samp_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end

      START: begin
        if (tick) begin
          if (samp_cnt_q == HALF_LAST) begin
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
            // Line back high at the start-bit centre means it was a glitch.
            state_d    = rx_s_q ? IDLE : DATA;
          end else begin
            samp_cnt_d = samp_cnt_q + SAMP_W'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (samp_cnt_q == FULL_LAST) begin
            samp_cnt_d = '0;
            // LSB arrives first, so shifting right leaves it at bit 0.
            shift_d    = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end else begin
            samp_cnt_d = samp_cnt_q + SAMP_W'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (samp_cnt_q == FULL_LAST) begin
            samp_cnt_d = '0;
            state_d    = IDLE;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              // An ack in this same cycle consumed the old byte: no overrun.
              if (valid_q && !rx_ack) begin
                overrun_d = 1'b1;
              end
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + SAMP_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchroniser presets to the idle level so reset never looks like a start edge.
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= rx;
      rx_s_q     <= sync1_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Drives serial frames into uart_rx (16 clk per bit). Expected events
//   (good byte or framing error) are queued when a frame is sent; a monitor
//   on the negative clock edge pops and compares whenever the receiver
//   presents a byte or a frame_err pulse, and acknowledges each byte.
//   Overrun and reset behaviour are exercised with the monitor parked.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int DW       = 8;
  localparam int BAUD     = 62500;
  localparam int CLK_MHZ  = 1;
  localparam int OS       = 16;
  localparam int BIT_CLKS = CLK_MHZ * 1_000_000 / BAUD;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          rx_ack;
  logic          mon_ack;
  logic          dir_ack;
  logic [DW-1:0] data_o;
  logic          rx_valid;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun;

  int total = 0;
  int bad   = 0;
  int lat   = 0;

  typedef struct {
    bit            ferr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 1'b0;

  assign rx_ack = mon_ack | dir_ack;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_WIDTH  (DW),
    .BAUDRATE    (BAUD),
    .CLK_FREQ_MHZ(CLK_MHZ),
    .OVERSAMPLE  (OS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_ack   (rx_ack),
    .data_o   (data_o),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit ferr, input logic [DW-1:0] d);
    exp_t e;
    e.ferr = ferr;
    e.data = d;
    return e;
  endfunction

  // Scoreboard monitor: compares each presented output with the oldest queued event.
  always @(negedge clk) begin
    exp_t e;
    mon_ack = 1'b0;
    if (mon_en) begin
      if (frame_err) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_frame_err: got frame_err=1 expected no event");
        end else begin
          e = exp_q.pop_front();
          if (!e.ferr) begin
            bad++;
            $display("FAIL event_kind: got frame_err expected byte 0x%0h", e.data);
          end
        end
      end
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got 0x%0h expected no event", data_o);
        end else begin
          e = exp_q.pop_front();
          check("event_is_byte", {31'd0, e.ferr}, 32'd0);
          check("rx_byte", {24'd0, data_o}, {24'd0, e.data});
          check("no_overrun", {31'd0, overrun}, 32'd0);
        end
        mon_ack = 1'b1;
      end
    end
  end

  // Caller is aligned to a negedge; holds the bit for BIT_CLKS clocks.
  task automatic send_bit(input logic b, input bit chk_busy);
    rx = b;
    repeat (BIT_CLKS / 2) @(negedge clk);
    if (chk_busy) check("busy_mid_bit", {31'd0, rx_busy}, 32'd1);
    repeat (BIT_CLKS - BIT_CLKS / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input bit chk_busy);
    send_bit(1'b0, chk_busy);
    for (int i = 0; i < DW; i++) send_bit(d[i], chk_busy);
    send_bit(stop, chk_busy);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    dir_ack = 1'b1;
    @(negedge clk);
    dir_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    rx      = 1'b1;
    dir_ack = 1'b0;
    mon_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_data", {24'd0, data_o}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    idle(20);

    // Single good frame 0x65, with latency measured for later cycle-exact acks
    mon_en = 1'b1;
    exp_q.push_back(mk(1'b0, 8'h65));
    fork
      send_frame(8'h65, 1'b1, 1'b1);
      begin
        lat = 0;
        while (!rx_valid && lat < 300) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("t1_latency_window", {31'd0, (lat >= 148 && lat <= 160)}, 32'd1);
    idle(20);
    check("t1_data_kept", {24'd0, data_o}, 32'h65);

    // Short glitch on an idle line
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    check("t2_valid", {31'd0, rx_valid}, 32'd0);
    check("t2_overrun", {31'd0, overrun}, 32'd0);
    check("t2_busy", {31'd0, rx_busy}, 32'd0);

    // Stop bit low: framing error, data untouched
    exp_q.push_back(mk(1'b1, 8'h00));
    send_frame(8'h5A, 1'b0, 1'b0);
    idle(20);
    check("t3_data_kept", {24'd0, data_o}, 32'h65);
    check("t3_valid", {31'd0, rx_valid}, 32'd0);
    check("t3_busy", {31'd0, rx_busy}, 32'd0);

    // Random frames: good, bad stop bit, glitches, gaps down to back-to-back
    for (int n = 0; n < 40; n++) begin
      int            kind;
      logic [DW-1:0] d;
      kind = $urandom_range(9);
      d    = DW'($urandom);
      if (kind < 8) begin
        exp_q.push_back(mk(1'b0, d));
        send_frame(d, 1'b1, 1'b0);
        idle($urandom_range(20));
      end else if (kind == 8) begin
        exp_q.push_back(mk(1'b1, 8'h00));
        send_frame(d, 1'b0, 1'b0);
        idle(4 + $urandom_range(16));
      end else begin
        rx = 1'b0;
        repeat (1 + $urandom_range(3)) @(negedge clk);
        idle(24);
      end
    end
    idle(40);
    check("rand_queue_drained", exp_q.size(), 32'd0);
    mon_en = 1'b0;

    // Back-to-back frames with no ack: overrun, newest byte wins
    send_frame(8'h66, 1'b1, 1'b0);
    send_frame(8'h67, 1'b1, 1'b0);
    idle(20);
    check("t4_data", {24'd0, data_o}, 32'h67);
    check("t4_valid", {31'd0, rx_valid}, 32'd1);
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    pulse_ack();
    check("t4_valid_cleared", {31'd0, rx_valid}, 32'd0);
    check("t4_overrun_cleared", {31'd0, overrun}, 32'd0);
    idle(20);

    // Ack in the very cycle the second byte completes: no overrun
    fork
      begin
        send_frame(8'h66, 1'b1, 1'b0);
        send_frame(8'h67, 1'b1, 1'b0);
      end
      begin
        repeat (10 * BIT_CLKS + lat - 1) @(negedge clk);
        check("t5_pending_data", {24'd0, data_o}, 32'h66);
        check("t5_pending_valid", {31'd0, rx_valid}, 32'd1);
        pulse_ack();
        check("t5_data", {24'd0, data_o}, 32'h67);
        check("t5_valid", {31'd0, rx_valid}, 32'd1);
        check("t5_overrun", {31'd0, overrun}, 32'd0);
      end
    join
    idle(20);
    pulse_ack();
    check("t5_valid_cleared", {31'd0, rx_valid}, 32'd0);

    // Reset in the middle of the data bits of 0xF0, then a clean 0xA5
    mon_en = 1'b1;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(((8'hF0 >> i) & 8'h01) != 0, 1'b0);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("t6_busy_before_rst", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_data", {24'd0, data_o}, 32'd0);
    check("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
    check("t6_rst_ferr", {31'd0, frame_err}, 32'd0);
    check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
    repeat (BIT_CLKS - BIT_CLKS / 2 - 1) @(negedge clk);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(40);
    check("t6_no_stray_valid", {31'd0, rx_valid}, 32'd0);
    check("t6_idle_busy", {31'd0, rx_busy}, 32'd0);
    exp_q.push_back(mk(1'b0, 8'hA5));
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(30);
    check("t6_queue_drained", exp_q.size(), 32'd0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
